// File: rtl/fir_pkg.sv
// Shared types and sizing for the reconfigurable transposed FIR tap scheduler.
package fir_pkg;

   localparam int NUM_BANK      = 4;
   localparam int TAPS_PER_BANK = 10;
   localparam int MAX_TAPS      = NUM_BANK * TAPS_PER_BANK;
   localparam int DATA_W        = 16;

   // Widths of a global tap index, a bank number and a bank-local address
   localparam int IDX_W  = 6;
   localparam int BANK_W = 3;
   localparam int LOC_W  = 4;

   typedef enum logic [2:0] {
      IDLE,
      UPDATE,
      READ,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/fir_addr_split.sv
// Splits a global tap index into {bank, bank-local address, in-range flag}.
module fir_addr_split
   import fir_pkg::*;
#(
   parameter int TAPS  = TAPS_PER_BANK,
   parameter int LIMIT = MAX_TAPS
) (
   input  logic [IDX_W-1:0]  idx,
   output logic [BANK_W-1:0] bank,
   output logic [LOC_W-1:0]  localIdx,
   output logic              valid
);

   // Divide-by-TAPS as a compare chain; the highest bank base not above idx wins
   always_comb begin
      bank     = '0;
      localIdx = LOC_W'(idx);
      for (int b = 1; b < (1 << BANK_W); b++) begin
         if (int'(idx) >= b * TAPS) begin
            bank     = BANK_W'(b);
            localIdx = LOC_W'(int'(idx) - b * TAPS);
         end
      end
      valid = int'(idx) < LIMIT;
   end

endmodule

// File: rtl/fir_tap_scheduler.sv
// Coefficient bank router and sweep sequencer for the transposed FIR MAC slices.
module fir_tap_scheduler #(
   parameter int NUM_BANK      = fir_pkg::NUM_BANK,
   parameter int TAPS_PER_BANK = fir_pkg::TAPS_PER_BANK,
   parameter int DATA_W        = fir_pkg::DATA_W
) (
   input  logic                     iClk_12M,
   input  logic                     iRsn,
   input  logic                     iEnSample_300k,
   input  logic                     iCoeffiUpdateFlag,
   input  logic                     iCsnRam,
   input  logic                     iWrnRam,
   input  logic [5:0]               iAddrRam,
   input  logic signed [DATA_W-1:0] iWrDtRam,
   input  logic [5:0]               iNumOfCoeff,
   output logic [NUM_BANK-1:0]      oCsnRam,
   output logic [NUM_BANK-1:0]      oWrnRam,
   output logic [3:0]               oAddrRam [NUM_BANK],
   output logic signed [DATA_W-1:0] oWrDtRam [NUM_BANK],
   output logic [NUM_BANK-1:0]      oEnMul,
   output logic [NUM_BANK-1:0]      oEnAcc,
   output logic                     oEnDelay,
   output logic                     oBusy,
   output logic                     oDone,
   output logic                     oReject
);
   import fir_pkg::*;

   localparam int TapLimit = NUM_BANK * TAPS_PER_BANK;

   state_t                     state, stateNext;
   logic [3:0]                 rdLocal;
   logic [5:0]                 tapCount;
   logic                       hostWr;
   logic [2:0]                 wrBank, cntBank;
   logic [3:0]                 wrLocal, cntLocal;
   logic                       wrValid, cntValid;
   logic                       rejectNext;
   logic [NUM_BANK-1:0]        enMulNext;
   logic                       vld_p1;
   logic [2:0]                 wrBank_p1;
   logic [3:0]                 wrLocal_p1;
   logic signed [DATA_W-1:0]   wrData_p1;
   logic [NUM_BANK-1:0]        enMul_p1;
   logic                       reject_p1;

   // Tap counts above the bank capacity behave as a full filter
   function automatic logic [5:0] satCount(input logic [5:0] n);
      return (int'(n) > TapLimit) ? 6'(TapLimit) : n;
   endfunction

   assign hostWr = !iCsnRam && !iWrnRam;

   fir_addr_split #(.TAPS(TAPS_PER_BANK), .LIMIT(TapLimit)) uWrSplit (
      .idx(iAddrRam), .bank(wrBank), .localIdx(wrLocal), .valid(wrValid)
   );

   // The latched count split the same way gives the bank/local boundary for gating
   fir_addr_split #(.TAPS(TAPS_PER_BANK), .LIMIT(TapLimit)) uCntSplit (
      .idx(tapCount), .bank(cntBank), .localIdx(cntLocal), .valid(cntValid)
   );

   // State register
   always_ff @(posedge iClk_12M) begin
      if (iRsn) state <= IDLE;
      else      state <= stateNext;
   end

   // Next-state logic; an update request during a sweep waits for DONE
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (iCoeffiUpdateFlag)   stateNext = UPDATE;
            else if (iEnSample_300k) stateNext = READ;
         end
         UPDATE:  if (!iCoeffiUpdateFlag) stateNext = IDLE;
         READ:    if (rdLocal == 4'(TAPS_PER_BANK - 1)) stateNext = DRAIN;
         DRAIN:   stateNext = DONE;
         DONE:    stateNext = iCoeffiUpdateFlag ? UPDATE : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Sweep address counter and tap-count latch, both loaded on sweep entry
   always_ff @(posedge iClk_12M) begin
      if (iRsn) begin
         rdLocal  <= '0;
         tapCount <= '0;
      end else if (state == IDLE && stateNext == READ) begin
         rdLocal  <= '0;
         tapCount <= satCount(iNumOfCoeff);
      end else if (state == READ) begin
         rdLocal  <= rdLocal + 4'd1;
      end
   end

   // Tap k = b*TAPS_PER_BANK + rdLocal is live only below the latched count
   always_comb begin
      enMulNext = '0;
      for (int b = 0; b < NUM_BANK; b++) begin
         enMulNext[b] = (state == READ) &&
                        (!cntValid || b < int'(cntBank) ||
                         (b == int'(cntBank) && rdLocal < cntLocal));
      end
   end

   assign rejectNext = (hostWr && (state != UPDATE || !wrValid)) ||
                       (iEnSample_300k && (state != IDLE || iCoeffiUpdateFlag));

   // Stage p1 control: enables line up with the one-cycle SRAM read latency
   always_ff @(posedge iClk_12M) begin
      if (iRsn) begin
         enMul_p1  <= '0;
         reject_p1 <= 1'b0;
         vld_p1    <= 1'b0;
      end else begin
         enMul_p1  <= enMulNext;
         reject_p1 <= rejectNext;
         vld_p1    <= hostWr && (state == UPDATE) && wrValid;
      end
   end

   // Stage p1 data: host write fields, qualified downstream by vld_p1
   always_ff @(posedge iClk_12M) begin
      wrBank_p1  <= wrBank;
      wrLocal_p1 <= wrLocal;
      wrData_p1  <= iWrDtRam;
   end

   // Bank ports: a sweep reads every bank in lockstep, else only the addressed bank is written
   always_comb begin
      oCsnRam = '1;
      oWrnRam = '1;
      for (int b = 0; b < NUM_BANK; b++) begin
         oAddrRam[b] = '0;
         oWrDtRam[b] = '0;
      end
      if (state == READ) begin
         oCsnRam = '0;
         for (int b = 0; b < NUM_BANK; b++) oAddrRam[b] = rdLocal;
      end else if (vld_p1) begin
         for (int b = 0; b < NUM_BANK; b++) begin
            if (int'(wrBank_p1) == b) begin
               oCsnRam[b]  = 1'b0;
               oWrnRam[b]  = 1'b0;
               oAddrRam[b] = wrLocal_p1;
               oWrDtRam[b] = wrData_p1;
            end
         end
      end
   end

   assign oEnMul   = enMul_p1;
   assign oEnAcc   = {NUM_BANK{state == DONE}};
   assign oEnDelay = (state == DONE);
   assign oDone    = (state == DONE);
   assign oBusy    = (state == READ) || (state == DRAIN) || (state == DONE);
   assign oReject  = reject_p1;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler: write routing table, sweep gating table, corner sequences.
module tb_fir_tap_scheduler;

   logic               clk = 1'b0;
   logic               iRsn, iEnSample_300k, iCoeffiUpdateFlag, iCsnRam, iWrnRam;
   logic [5:0]         iAddrRam, iNumOfCoeff;
   logic signed [15:0] iWrDtRam;
   logic [3:0]         oCsnRam, oWrnRam, oEnMul, oEnAcc;
   logic [3:0]         oAddrRam [4];
   logic signed [15:0] oWrDtRam [4];
   logic               oEnDelay, oBusy, oDone, oReject;

   int nChecks = 0;
   int nErr    = 0;

   typedef struct {
      logic [5:0]  addr;
      logic [15:0] data;
      logic [3:0]  csn;
      logic [15:0] abus;
      logic [63:0] dbus;
      logic        rej;
   } wrVec_t;

   typedef struct {
      logic [5:0] cnt;
      int         n0, n1, n2, n3;
   } swVec_t;

   wrVec_t wv[7];
   swVec_t sv[7];

   fir_tap_scheduler dut (
      .iClk_12M(clk), .iRsn(iRsn), .iEnSample_300k(iEnSample_300k),
      .iCoeffiUpdateFlag(iCoeffiUpdateFlag), .iCsnRam(iCsnRam), .iWrnRam(iWrnRam),
      .iAddrRam(iAddrRam), .iWrDtRam(iWrDtRam), .iNumOfCoeff(iNumOfCoeff),
      .oCsnRam(oCsnRam), .oWrnRam(oWrnRam), .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam),
      .oEnMul(oEnMul), .oEnAcc(oEnAcc), .oEnDelay(oEnDelay), .oBusy(oBusy),
      .oDone(oDone), .oReject(oReject)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [15:0] abus();
      return {oAddrRam[3], oAddrRam[2], oAddrRam[1], oAddrRam[0]};
   endfunction

   function automatic logic [63:0] dbus();
      return {oWrDtRam[3], oWrDtRam[2], oWrDtRam[1], oWrDtRam[0]};
   endfunction

   task automatic chkIdlePorts(input string tag);
      chk({tag, "_csn"},  64'(oCsnRam), 64'hF);
      chk({tag, "_wrn"},  64'(oWrnRam), 64'hF);
      chk({tag, "_addr"}, 64'(abus()), 64'h0);
      chk({tag, "_data"}, dbus(), 64'h0);
   endtask

   // Strobe at cycle 0, then check cycles 1..13; optional extra strobe / flag rise at given cycles
   task automatic sweep(input logic [5:0] cnt, input int n0, input int n1, input int n2,
                        input int n3, input int strobeAt, input int flagAt);
      int         n[4];
      logic [3:0] expMul;
      n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
      iNumOfCoeff    = cnt;
      iEnSample_300k = 1'b1;
      step();
      iEnSample_300k = 1'b0;
      iNumOfCoeff    = 6'd0;
      for (int c = 1; c <= 13; c++) begin
         expMul = '0;
         if (c >= 2 && c <= 11)
            for (int b = 0; b < 4; b++) expMul[b] = ((c - 2) < n[b]);
         chk("sw_busy",   64'(oBusy),    64'(c <= 12));
         chk("sw_enMul",  64'(oEnMul),   64'(expMul));
         chk("sw_csn",    64'(oCsnRam),  (c <= 10) ? 64'h0 : 64'hF);
         chk("sw_wrn",    64'(oWrnRam),  64'hF);
         if (c <= 10) chk("sw_addr", 64'(abus()), 64'({4{4'(c - 1)}}));
         chk("sw_done",   64'(oDone),    64'(c == 12));
         chk("sw_enAcc",  64'(oEnAcc),   (c == 12) ? 64'hF : 64'h0);
         chk("sw_enDly",  64'(oEnDelay), 64'(c == 12));
         chk("sw_reject", 64'(oReject),  64'(c == strobeAt + 1));
         iEnSample_300k = (c == strobeAt);
         if (c == flagAt) iCoeffiUpdateFlag = 1'b1;
         step();
      end
      iEnSample_300k = 1'b0;
   endtask

   task automatic hostWrite(input logic [5:0] a, input logic [15:0] d);
      iCsnRam  = 1'b0;
      iWrnRam  = 1'b0;
      iAddrRam = a;
      iWrDtRam = d;
      step();
      iCsnRam  = 1'b1;
      iWrnRam  = 1'b1;
   endtask

   initial begin
      logic doneSeen;

      wv[0] = '{6'd23, 16'h1234, 4'b1011, 16'h0300, 64'h0000_1234_0000_0000, 1'b0};
      wv[1] = '{6'd0,  16'h8001, 4'b1110, 16'h0000, 64'h0000_0000_0000_8001, 1'b0};
      wv[2] = '{6'd9,  16'h7FFF, 4'b1110, 16'h0009, 64'h0000_0000_0000_7FFF, 1'b0};
      wv[3] = '{6'd10, 16'hFFFF, 4'b1101, 16'h0000, 64'h0000_0000_FFFF_0000, 1'b0};
      wv[4] = '{6'd39, 16'h0042, 4'b0111, 16'h9000, 64'h0042_0000_0000_0000, 1'b0};
      wv[5] = '{6'd45, 16'hAAAA, 4'b1111, 16'h0000, 64'h0, 1'b1};
      wv[6] = '{6'd40, 16'h5555, 4'b1111, 16'h0000, 64'h0, 1'b1};

      sv[0] = '{6'd40, 10, 10, 10, 10};
      sv[1] = '{6'd13, 10,  3,  0,  0};
      sv[2] = '{6'd0,   0,  0,  0,  0};
      sv[3] = '{6'd25, 10, 10,  5,  0};
      sv[4] = '{6'd39, 10, 10, 10,  9};
      sv[5] = '{6'd1,   1,  0,  0,  0};
      sv[6] = '{6'd55, 10, 10, 10, 10};

      iRsn = 1'b1; iEnSample_300k = 1'b0; iCoeffiUpdateFlag = 1'b0;
      iCsnRam = 1'b1; iWrnRam = 1'b1; iAddrRam = '0; iWrDtRam = '0; iNumOfCoeff = '0;
      step();
      step();
      iRsn = 1'b0;

      // Reset state, then after 20 idle cycles
      chkIdlePorts("rst");
      chk("rst_enMul", 64'(oEnMul), 64'h0);
      chk("rst_misc", 64'({oEnAcc, oEnDelay, oBusy, oDone, oReject}), 64'h0);
      for (int i = 0; i < 20; i++) step();
      chkIdlePorts("idle");
      chk("idle_en", 64'({oEnMul, oEnAcc, oEnDelay, oBusy, oDone, oReject}), 64'h0);

      // Host write routing in UPDATE
      iCoeffiUpdateFlag = 1'b1;
      step();
      for (int i = 0; i < 7; i++) begin
         hostWrite(wv[i].addr, wv[i].data);
         chk("wr_csn",    64'(oCsnRam), 64'(wv[i].csn));
         chk("wr_wrn",    64'(oWrnRam), 64'(wv[i].csn));
         chk("wr_addr",   64'(abus()),  64'(wv[i].abus));
         chk("wr_data",   dbus(),       wv[i].dbus);
         chk("wr_reject", 64'(oReject), 64'(wv[i].rej));
         step();
         chkIdlePorts("wr_after");
      end
      iCoeffiUpdateFlag = 1'b0;
      step();

      // Write while IDLE is dropped
      hostWrite(6'd5, 16'h0F0F);
      chk("idlewr_reject", 64'(oReject), 64'h1);
      chkIdlePorts("idlewr");
      step();
      chk("idlewr_pulse", 64'(oReject), 64'h0);

      // Strobe with flag high is dropped and no sweep starts
      iCoeffiUpdateFlag = 1'b1;
      iEnSample_300k    = 1'b1;
      step();
      iEnSample_300k    = 1'b0;
      iCoeffiUpdateFlag = 1'b0;
      chk("flagstb_reject", 64'(oReject), 64'h1);
      chk("flagstb_busy",   64'(oBusy),   64'h0);
      step();
      chk("flagstb_busy2",  64'(oBusy),   64'h0);
      step();

      // Tap-count gating table
      for (int i = 0; i < 7; i++) begin
         sweep(sv[i].cnt, sv[i].n0, sv[i].n1, sv[i].n2, sv[i].n3, -1, -1);
         step();
      end

      // Strobe during a sweep is rejected and the sweep is unchanged
      sweep(6'd40, 10, 10, 10, 10, 5, -1);
      step();

      // Flag rise mid-sweep: sweep completes, then UPDATE accepts a write
      sweep(6'd13, 10, 3, 0, 0, -1, 4);
      hostWrite(6'd23, 16'h0BEE);
      chk("postdone_csn",    64'(oCsnRam), 64'hB);
      chk("postdone_addr",   64'(abus()),  64'h0300);
      chk("postdone_reject", 64'(oReject), 64'h0);
      iCoeffiUpdateFlag = 1'b0;
      step();
      step();

      // Reset in the middle of a sweep
      iNumOfCoeff    = 6'd40;
      iEnSample_300k = 1'b1;
      step();
      iEnSample_300k = 1'b0;
      for (int c = 1; c < 6; c++) step();
      chk("midrst_pre_enMul", 64'(oEnMul), 64'hF);
      iRsn = 1'b1;
      step();
      iRsn = 1'b0;
      chk("midrst_enMul", 64'(oEnMul), 64'h0);
      chk("midrst_busy",  64'(oBusy),  64'h0);
      chk("midrst_csn",   64'(oCsnRam), 64'hF);
      doneSeen = oDone;
      for (int i = 0; i < 8; i++) begin
         step();
         doneSeen = doneSeen | oDone | oBusy;
      end
      chk("midrst_nodone", 64'(doneSeen), 64'h0);
      sweep(6'd40, 10, 10, 10, 10, -1, -1);

      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end

endmodule
